nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit digits per operand; legal range 2..16.
REQ-002 Operand width W SHALL be 4*NIBBLES bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  W  operand A, unsigned.
REQ-008 b  input  W  operand B, unsigned.
REQ-009 cin  input  1  carry-in to the least-significant nibble.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 sum  output  W  registered sum.
REQ-013 carry_out  output  1  registered carry out of the MSB nibble.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; the accept condition is in_valid && in_ready.
REQ-017 On accept: latch a and b, set the carry register to cin, clear the nibble index, clear sum, and go to RUN.
REQ-018 In RUN, each cycle: add a[idx], b[idx] and the carry register in a 4-bit stage; write the result into sum[idx]; load the stage carry into the carry register; increment idx.
REQ-019 When idx == NIBBLES-1 in RUN, after that nibble completes: carry_out takes the final carry, and the state goes to DONE.
REQ-020 out_valid SHALL be 1 exactly in DONE.
REQ-021 Latency: out_valid rises NIBBLES cycles after the accept edge; throughput is one operation per NIBBLES+2 cycles at most.
REQ-022 DONE: hold sum and carry_out stable until out_ready=1, then go to IDLE on that edge.
REQ-023 Backpressure: sum, carry_out and out_valid SHALL NOT change while out_valid && !out_ready.
REQ-024 in_valid in RUN or DONE is ignored; a, b and cin are not sampled.
REQ-025 Arithmetic: {carry_out, sum} SHALL equal a + b + cin modulo 2^(W+1).
REQ-026 Wrap-around: an all-ones operand plus 1 SHALL give sum = 0 and carry_out = 1.

Reset
REQ-027 rst=1 on any edge, including mid-RUN or in DONE, SHALL force IDLE, drop the partial result, and make in_ready=1 on the next cycle.
REQ-028 Reset values: out_valid=0, busy=0, sum=0, carry_out=0, idx=0, carry register=0; ovf=0 when present.
REQ-029 rst SHALL have priority over accept and out_ready in the same cycle.

Configuration
REQ-030 Macro NSA_OVERFLOW_EN defined: add output port ovf (1 bit), registered with carry_out, equal to carry into the MSB bit XOR carry out of the MSB bit (two's-complement overflow).
REQ-031 Macro undefined: no ovf port and no related logic; all other behaviour is identical.

Structure
REQ-032 Shared package nsa_pkg SHALL hold the FSM state enum typedef and the constant NIBBLE_W = 4.
REQ-033 The 4-bit add SHALL be one combinational sub-module, add4_stage (a4, b4, ci -> s4, co, c3 = carry into bit 3).
REQ-034 Operand and nibble-index selection, and the FSM, SHALL live in nibble_serial_adder.

Verification (NIBBLES=4)
REQ-035 a=0x0001, b=0x000A, cin=0 -> 4 cycles after accept: out_valid=1, sum=0x000B, carry_out=0.
REQ-036 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry_out=1; ovf=0 with the macro.
REQ-037 a=0x7FFF, b=0x0001, cin=0, macro defined -> sum=0x8000, carry_out=0, ovf=1.
REQ-038 a=0x6B3E, b=0xF0F1, cin=1; out_ready low for 3 cycles -> sum=0x5C30 and carry_out=1 held stable; IDLE one edge after out_ready=1.
REQ-039 Accept a=0x1234, b=0x1111; assert rst on the 2nd RUN cycle -> next cycle out_valid=0, sum=0, in_ready=1; a new operation then completes correctly.
REQ-040 in_valid pulsed during RUN with different operands -> ignored; the first operation's result is unchanged.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and digit width.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/add4_stage.sv
// One combinational 4-bit ripple stage; c3 exposes the carry into bit 3 so the
// caller can derive two's-complement overflow from the most significant digit.
module add4_stage
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co,
  output logic                c3
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
    assign s4[gi]    = a4[gi] ^ b4[gi] ^ w_c[gi];
    assign w_c[gi+1] = (a4[gi] & b4[gi]) | (w_c[gi] & (a4[gi] ^ b4[gi]));
  end

  assign co = w_c[NIBBLE_W];
  assign c3 = w_c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two NIBBLES-digit operands one nibble per cycle through a single add4_stage.
// Define NSA_OVERFLOW_EN to add the registered two's-complement overflow output ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          carry_out,
  output logic                          busy
`ifdef NSA_OVERFLOW_EN
  ,
  output logic                          ovf
`endif
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  nsa_state_t r_state;
  nsa_state_t w_state_next;

  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [W-1:0]        r_sum;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic                r_carry_out;

  logic [NIBBLE_W-1:0] w_a4;
  logic [NIBBLE_W-1:0] w_b4;
  logic [NIBBLE_W-1:0] w_s4;
  logic                w_co;
  logic                w_accept;
  logic                w_last;

`ifdef NSA_OVERFLOW_EN
  logic                r_ovf;
  logic                w_c3;
`else
  logic                w_c3_unused;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_a4     = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
  assign w_b4     = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

  add4_stage u_stage (
    .a4 (w_a4),
    .b4 (w_b4),
    .ci (r_carry),
    .s4 (w_s4),
    .co (w_co),
`ifdef NSA_OVERFLOW_EN
    .c3 (w_c3)
`else
    .c3 (w_c3_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Result registers only move on accept or in RUN, so DONE holds them under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      r_ovf       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a         <= a;
      r_b         <= b;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= cin;
      r_carry_out <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      r_ovf       <= 1'b0;
`endif
    end else if (r_state == ST_RUN) begin
      r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s4;
      r_carry <= w_co;
      if (w_last) begin
        r_idx       <= '0;
        r_carry_out <= w_co;
`ifdef NSA_OVERFLOW_EN
        r_ovf       <= w_c3 ^ w_co;
`endif
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
`ifdef NSA_OVERFLOW_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed checks of nibble_serial_adder (NIBBLES=4) against an arithmetic model and literals.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;
`ifdef NSA_OVERFLOW_EN
  logic         ovf;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W:0] exp_res = '0;
  logic       exp_ovf = 1'b0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
`ifdef NSA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) begin
      pass_cnt++;
      $display("ok   %s: %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [W:0] model_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Overflow as the operands' signed sum leaving the W-bit two's-complement range.
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint sx, sy, r;
    sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    r  = sx + sy + longint'(c);
    return (r > ((longint'(1) << (W-1)) - 1)) || (r < -(longint'(1) << (W-1)));
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("cmp_sum", 64'(sum), 64'(exp_res[W-1:0]));
      check("cmp_co", 64'(carry_out), 64'(exp_res[W]));
`ifdef NSA_OVERFLOW_EN
      check("cmp_ovf", 64'(ovf), 64'(exp_ovf));
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic [W-1:0] lit_sum, input logic lit_co, input logic lit_ovf,
                        input int hold, input bit glitch);
    int cyc;
    bit seen;
    a        = ta;
    b        = tb_v;
    cin      = tcin;
    in_valid = 1'b1;
    exp_res  = model_sum(ta, tb_v, tcin);
    exp_ovf  = model_ovf(ta, tb_v, tcin);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (glitch && cyc == 1) begin
        in_valid = 1'b1;
        a        = ~ta;
        b        = 16'h5A5A;
        cin      = ~tcin;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      seen = out_valid;
    end
    in_valid = 1'b0;
    check("latency", 64'(cyc), 64'(NIBBLES));
    check("lit_sum", 64'(sum), 64'(lit_sum));
    check("lit_co", 64'(carry_out), 64'(lit_co));
`ifdef NSA_OVERFLOW_EN
    check("lit_ovf", 64'(ovf), 64'(lit_ovf));
`else
    if (lit_ovf) begin end
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_sum", 64'(sum), 64'(lit_sum));
      check("bp_co", 64'(carry_out), 64'(lit_co));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", 64'(carry_out), 64'd0);
`ifdef NSA_OVERFLOW_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h0001, 16'h000A, 1'b0, 16'h000B, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h6B3E, 16'hF0F1, 1'b1, 16'h5C30, 1'b1, 1'b0, 3, 1'b0);
    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0);

    // Reset on the second RUN edge drops the partial result.
    a        = 16'h1234;
    b        = 16'h1111;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_valid", 64'(out_valid), 64'd0);
    check("midrun_rst_sum", 64'(sum), 64'd0);
    check("midrun_rst_ready", 64'(in_ready), 64'd1);
    check("midrun_rst_busy", 64'(busy), 64'd0);
    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0, 1'b0);

    // Reset in DONE wins over a simultaneous out_ready.
    a        = 16'hFFFF;
    b        = 16'h0001;
    cin      = 1'b0;
    exp_res  = model_sum(16'hFFFF, 16'h0001, 1'b0);
    exp_ovf  = model_ovf(16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (NIBBLES) @(negedge clk);
    check("done_before_rst", 64'(out_valid), 64'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    check("done_rst_co", 64'(carry_out), 64'd0);
    check("done_rst_valid", 64'(out_valid), 64'd0);
    check("done_rst_ready", 64'(in_ready), 64'd1);

    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
